rps_match_scorer: RTL and testbench
===================================

RPS_MATCH_SCORER -- requirements
Module: rps_match_scorer

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 3, giving the round wins needed to take the match (legal range 1..7).
REQ-002 SHALL have parameter TIE_LIMIT, default 4, giving the consecutive ties that end the match as a draw (legal range 1..15; used only with RPS_TIE_LIMIT_EN).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port new_match, input, 1, a one-cycle request to clear scores and start a match.
REQ-006 SHALL have port round_valid, input, 1, which qualifies round_result.
REQ-007 SHALL have port round_result, input, 2, the round outcome: 00 tie, 01 P1 win, 10 P2 win, 11 invalid.
REQ-008 SHALL have port round_ready, output, 1, high when a round is accepted this cycle.
REQ-009 SHALL have ports score_p1 and score_p2, output, 3 each, the round wins in the current match.
REQ-010 SHALL have port tie_cnt, output, 4, the total ties this match, saturating at 15.
REQ-011 SHALL have port invalid_cnt, output, 4, the invalid rounds this match, saturating at 15.
REQ-012 SHALL have port match_done, output, 1, high while in DONE.
REQ-013 SHALL have port match_winner, output, 2, the result: 00 draw or none, 01 P1, 10 P2, 11 reserved and never driven.

Function
REQ-014 SHALL implement the FSM states IDLE, PLAY and DONE.
REQ-015 In IDLE, round_ready SHALL be 0 and new_match SHALL move the FSM to PLAY, clearing all counters.
REQ-016 In PLAY, round_ready SHALL be 1, and a round SHALL be accepted in any cycle with round_valid=1.
REQ-017 An accepted round SHALL update the counters at the next clock edge (one-cycle latency to the outputs).
REQ-018 Result 01 SHALL increment score_p1; if the new value equals WIN_TARGET, the FSM SHALL enter DONE on the same edge with match_winner=01.
REQ-019 Result 10 SHALL behave the same as REQ-018 for score_p2, with match_winner=10.
REQ-020 Result 00 SHALL increment tie_cnt (saturating) and the internal consecutive-tie streak.
REQ-021 Result 01 or 10 SHALL clear the tie streak.
REQ-022 Result 11 SHALL increment invalid_cnt (saturating), change no score and leave the tie streak unchanged.
REQ-023 In DONE, round_ready SHALL be 0; round_valid SHALL be ignored; scores, counts and match_winner SHALL hold until new_match.
REQ-024 new_match in DONE or PLAY SHALL restart the match: it enters PLAY next cycle with all counters and match_winner cleared.
REQ-025 new_match in PLAY together with round_valid SHALL take priority, and that round SHALL be discarded.
REQ-026 Scores SHALL never exceed WIN_TARGET; both scores SHALL never reach WIN_TARGET together, since one round changes one score.

Reset
REQ-027 rst=1 at any clock edge SHALL force IDLE, all counters to 0, match_winner=00, match_done=0 and round_ready=0, overriding all other inputs, including mid-match.

Configuration
REQ-028 The macro RPS_TIE_LIMIT_EN SHALL control the tie-limit draw feature.
REQ-029 With RPS_TIE_LIMIT_EN defined, an accepted tie that brings the streak to TIE_LIMIT SHALL enter DONE on that edge with match_winner=00.
REQ-030 Without RPS_TIE_LIMIT_EN, the streak counter SHALL not be built, TIE_LIMIT SHALL be unused, and ties SHALL never end a match.

Structure
REQ-031 Package rps_pkg SHALL hold the round/winner result-code constants (TIE, P1, P2, INVALID) and the FSM state typedef (IDLE, PLAY, DONE).
REQ-032 Sub-module rps_sat_counter, parameterized width with clear and increment inputs, SHALL implement tie_cnt, invalid_cnt and the tie streak.

Verification
REQ-033 Reset, then new_match, then results 01,01,01 -> score_p1=3, match_done=1 and match_winner=01 one cycle after the third round; round_ready=0.
REQ-034 Results 10,00,01,10,10 -> score_p2=3, score_p1=1, tie_cnt=1, match_winner=10.
REQ-035 Results 11 ×17 -> invalid_cnt saturates at 15, scores stay 0, FSM stays in PLAY.
REQ-036 With RPS_TIE_LIMIT_EN, results 00 ×4 -> DONE with match_winner=00; results 00,00,00,01,00 -> still PLAY, streak=1.
REQ-037 In DONE, round_valid with 01 -> no change; then new_match with round_valid=1 and 01 in the same cycle -> PLAY, all counters 0, the round discarded.
REQ-038 rst asserted mid-match at score 2-1 -> next cycle IDLE, all outputs 0, round_ready=0 until new_match.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors match scorer:
// round/winner result codes and FSM state encodings.
package rps_pkg;

    // Round outcome codes on round_result; P1/P2 double as match_winner codes.
    localparam logic [1:0] TIE      = 2'b00;
    localparam logic [1:0] P1       = 2'b01;
    localparam logic [1:0] P2       = 2'b10;
    localparam logic [1:0] INVALID  = 2'b11;

    // match_winner value for "draw or no result yet".
    localparam logic [1:0] WIN_NONE = 2'b00;

    // Match FSM state type, kept as plain constants for legacy tool flows.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t PLAY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/rps_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment;
// the count sticks at all-ones instead of wrapping.
module rps_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, else increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors match scorer: tracks round wins, ties and invalid
// rounds, and declares the match winner at WIN_TARGET round wins.
// Optional feature macro RPS_TIE_LIMIT_EN: when defined, TIE_LIMIT
// consecutive ties end the match as a draw; when undefined, no tie-streak
// counter exists and ties never end a match.
module rps_match_scorer
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int TIE_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_match,
    input  logic       round_valid,
    input  logic [1:0] round_result,
    output logic       round_ready,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic [3:0] tie_cnt,
    output logic [3:0] invalid_cnt,
    output logic       match_done,
    output logic [1:0] match_winner
);

    localparam logic [2:0] WIN_SCORE = 3'(WIN_TARGET);

    // Reject parameter values outside the encodable ranges at elaboration.
    if (WIN_TARGET < 1 || WIN_TARGET > 7 || TIE_LIMIT < 1 || TIE_LIMIT > 15) begin : g_param_check
        $error("rps_match_scorer: WIN_TARGET must be 1..7 and TIE_LIMIT 1..15");
    end

    state_t     state_q, state_d;
    logic [2:0] score_p1_q, score_p1_d;
    logic [2:0] score_p2_q, score_p2_d;
    logic [1:0] winner_q, winner_d;

    logic accept;
    logic is_tie, is_p1, is_p2, is_invalid;
    logic tie_limit_hit;

    // A round is taken only while playing, and a same-cycle restart discards it.
    assign round_ready = (state_q == PLAY);
    assign accept      = round_ready && round_valid && !new_match;
    assign is_tie      = accept && (round_result == TIE);
    assign is_p1       = accept && (round_result == P1);
    assign is_p2       = accept && (round_result == P2);
    assign is_invalid  = accept && (round_result == INVALID);

    rps_sat_counter #(.WIDTH(4)) u_tie_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (new_match),
        .inc   (is_tie),
        .count (tie_cnt)
    );

    rps_sat_counter #(.WIDTH(4)) u_invalid_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (new_match),
        .inc   (is_invalid),
        .count (invalid_cnt)
    );

`ifdef RPS_TIE_LIMIT_EN
    logic [3:0] tie_streak;

    // Decisive rounds break the streak; invalid rounds leave it alone.
    rps_sat_counter #(.WIDTH(4)) u_tie_streak (
        .clk   (clk),
        .rst   (rst),
        .clr   (new_match || is_p1 || is_p2),
        .inc   (is_tie),
        .count (tie_streak)
    );

    // The tie being accepted now is the one that reaches the limit.
    assign tie_limit_hit = is_tie && (tie_streak == 4'(TIE_LIMIT - 1));
`else
    assign tie_limit_hit = 1'b0;
`endif

    // Next-state and score update; restart outranks any round outcome.
    always_comb begin
        state_d    = state_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        winner_d   = winner_q;
        if (new_match) begin
            state_d    = PLAY;
            score_p1_d = '0;
            score_p2_d = '0;
            winner_d   = WIN_NONE;
        end else if (is_p1) begin
            score_p1_d = score_p1_q + 3'd1;
            if (score_p1_d == WIN_SCORE) begin
                state_d  = DONE;
                winner_d = P1;
            end
        end else if (is_p2) begin
            score_p2_d = score_p2_q + 3'd1;
            if (score_p2_d == WIN_SCORE) begin
                state_d  = DONE;
                winner_d = P2;
            end
        end else if (tie_limit_hit) begin
            state_d  = DONE;
            winner_d = WIN_NONE;
        end
    end

    // State, score and winner registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            score_p1_q <= '0;
            score_p2_q <= '0;
            winner_q   <= WIN_NONE;
        end else begin
            state_q    <= state_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            winner_q   <= winner_d;
        end
    end

    assign score_p1     = score_p1_q;
    assign score_p2     = score_p2_q;
    assign match_done   = (state_q == DONE);
    assign match_winner = winner_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Self-checking bench for rps_match_scorer: a behavioural model pushes the
// expected outputs for every driven cycle into a queue, which is popped and
// compared after the clock edge; scenario tasks add targeted checks.
module tb_rps_match_scorer;

    localparam int WIN_TARGET = 3;
    localparam int TIE_LIMIT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_match = 1'b0;
    logic       round_valid = 1'b0;
    logic [1:0] round_result = 2'b00;
    logic       round_ready;
    logic [2:0] score_p1, score_p2;
    logic [3:0] tie_cnt, invalid_cnt;
    logic       match_done;
    logic [1:0] match_winner;

    rps_match_scorer #(.WIN_TARGET(WIN_TARGET), .TIE_LIMIT(TIE_LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_match    (new_match),
        .round_valid  (round_valid),
        .round_result (round_result),
        .round_ready  (round_ready),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .tie_cnt      (tie_cnt),
        .invalid_cnt  (invalid_cnt),
        .match_done   (match_done),
        .match_winner (match_winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic [1:0] winner;
        logic [2:0] p1;
        logic [2:0] p2;
        logic [3:0] ties;
        logic [3:0] inv;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: 0 idle, 1 play, 2 done.
    int m_state = 0, m_p1 = 0, m_p2 = 0, m_tie = 0, m_inv = 0, m_streak = 0, m_win = 0;

    task automatic model_step(input logic r, input logic nm, input logic rv, input logic [1:0] rr);
        if (r) begin
            m_state = 0; m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0; m_streak = 0; m_win = 0;
        end else if (nm) begin
            m_state = 1; m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0; m_streak = 0; m_win = 0;
        end else if (m_state == 1 && rv) begin
            case (rr)
                2'b00: begin
                    if (m_tie < 15) m_tie = m_tie + 1;
                    m_streak = m_streak + 1;
`ifdef RPS_TIE_LIMIT_EN
                    if (m_streak == TIE_LIMIT) begin m_state = 2; m_win = 0; end
`endif
                end
                2'b01: begin
                    m_p1 = m_p1 + 1; m_streak = 0;
                    if (m_p1 == WIN_TARGET) begin m_state = 2; m_win = 1; end
                end
                2'b10: begin
                    m_p2 = m_p2 + 1; m_streak = 0;
                    if (m_p2 == WIN_TARGET) begin m_state = 2; m_win = 2; end
                end
                default: if (m_inv < 15) m_inv = m_inv + 1;
            endcase
        end
    endtask

    // Drive one cycle, queue the model's expectation, compare after the edge.
    task automatic cycle(input logic r, input logic nm, input logic rv, input logic [1:0] rr);
        obs_t e;
        obs_t got;
        rst = r; new_match = nm; round_valid = rv; round_result = rr;
        model_step(r, nm, rv, rr);
        e.ready  = (m_state == 1);
        e.done   = (m_state == 2);
        e.winner = 2'(m_win);
        e.p1     = 3'(m_p1);
        e.p2     = 3'(m_p2);
        e.ties   = 4'(m_tie);
        e.inv    = 4'(m_inv);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = {round_ready, match_done, match_winner, score_p1, score_p2, tie_cnt, invalid_cnt};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL scoreboard txn %0d got %h expected %h", txn, got, e);
        end
        $display("txn %0d rst=%0b nm=%0b rv=%0b res=%02b -> rdy=%0b p1=%0d p2=%0d ties=%0d inv=%0d done=%0b win=%02b",
                 txn, r, nm, rv, rr, round_ready, score_p1, score_p2, tie_cnt, invalid_cnt, match_done, match_winner);
        txn++;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 1'b1, 2'b01);
        checks++;
        if ({round_ready, match_done, match_winner, score_p1} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", {round_ready, match_done, match_winner, score_p1});
        end
        // Rounds offered in IDLE are ignored.
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        checks++;
        if (score_p1 !== 3'd0 || round_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got p1=%0d rdy=%0b expected 0 0", score_p1, round_ready);
        end
    endtask

    task automatic test_p1_win();
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        checks++;
        if (match_done !== 1'b0) begin
            errors++;
            $display("FAIL p1_not_yet got done=%0b expected 0", match_done);
        end
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        checks++;
        if (score_p1 !== 3'd3 || match_done !== 1'b1 || match_winner !== 2'b01 || round_ready !== 1'b0) begin
            errors++;
            $display("FAIL p1_win got p1=%0d done=%0b win=%02b rdy=%0b expected 3 1 01 0",
                     score_p1, match_done, match_winner, round_ready);
        end
    endtask

    task automatic test_p2_win();
        logic [1:0] seq [5];
        seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b10; seq[4] = 2'b10;
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, seq[i]);
        checks++;
        if (score_p2 !== 3'd3 || score_p1 !== 3'd1 || tie_cnt !== 4'd1 || match_winner !== 2'b10) begin
            errors++;
            $display("FAIL p2_win got p2=%0d p1=%0d ties=%0d win=%02b expected 3 1 1 10",
                     score_p2, score_p1, tie_cnt, match_winner);
        end
    endtask

    task automatic test_invalid_sat();
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b1, 2'b11);
        checks++;
        if (invalid_cnt !== 4'd15 || score_p1 !== 3'd0 || score_p2 !== 3'd0 || round_ready !== 1'b1) begin
            errors++;
            $display("FAIL invalid_sat got inv=%0d p1=%0d p2=%0d rdy=%0b expected 15 0 0 1",
                     invalid_cnt, score_p1, score_p2, round_ready);
        end
    endtask

    task automatic test_ties();
`ifdef RPS_TIE_LIMIT_EN
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 2'b00);
        checks++;
        if (match_done !== 1'b1 || match_winner !== 2'b00) begin
            errors++;
            $display("FAIL tie_limit got done=%0b win=%02b expected 1 00", match_done, match_winner);
        end
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b0, 1'b1, 2'b11);
        cycle(1'b0, 1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b0, 1'b1, 2'b00);
        checks++;
        if (match_done !== 1'b0 || round_ready !== 1'b1) begin
            errors++;
            $display("FAIL streak_broken got done=%0b rdy=%0b expected 0 1", match_done, round_ready);
        end
        cycle(1'b0, 1'b0, 1'b1, 2'b00);
        checks++;
        if (match_done !== 1'b1 || match_winner !== 2'b00) begin
            errors++;
            $display("FAIL streak_limit got done=%0b win=%02b expected 1 00", match_done, match_winner);
        end
`else
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b1, 2'b00);
        checks++;
        if (match_done !== 1'b0 || round_ready !== 1'b1 || tie_cnt !== 4'd15) begin
            errors++;
            $display("FAIL ties_no_end got done=%0b rdy=%0b ties=%0d expected 0 1 15",
                     match_done, round_ready, tie_cnt);
        end
`endif
    endtask

    task automatic test_done_hold();
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b0, 1'b1, 2'b10);
        checks++;
        if (score_p1 !== 3'd3 || score_p2 !== 3'd0 || match_done !== 1'b1 || match_winner !== 2'b01) begin
            errors++;
            $display("FAIL done_hold got p1=%0d p2=%0d done=%0b win=%02b expected 3 0 1 01",
                     score_p1, score_p2, match_done, match_winner);
        end
        cycle(1'b0, 1'b1, 1'b1, 2'b01);
        checks++;
        if (round_ready !== 1'b1 || score_p1 !== 3'd0 || match_winner !== 2'b00 || match_done !== 1'b0) begin
            errors++;
            $display("FAIL done_restart got rdy=%0b p1=%0d win=%02b done=%0b expected 1 0 00 0",
                     round_ready, score_p1, match_winner, match_done);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b1, 1'b1, 2'b10);
        checks++;
        if (score_p2 !== 3'd0 || tie_cnt !== 4'd0 || round_ready !== 1'b1) begin
            errors++;
            $display("FAIL play_restart got p2=%0d ties=%0d rdy=%0b expected 0 0 1", score_p2, tie_cnt, round_ready);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 2'b10);
        checks++;
        if (match_winner !== 2'b10 || score_p2 !== 3'd3) begin
            errors++;
            $display("FAIL b2b_p2 got win=%02b p2=%0d expected 10 3", match_winner, score_p2);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b1, 1'b1, 1'b1, 2'b01);
        checks++;
        if ({round_ready, match_done, match_winner, score_p1, score_p2, tie_cnt, invalid_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid got p1=%0d p2=%0d rdy=%0b expected all 0", score_p1, score_p2, round_ready);
        end
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b0, 1'b1, 2'b01);
        checks++;
        if (round_ready !== 1'b0 || score_p1 !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%0b p1=%0d expected 0 0", round_ready, score_p1);
        end
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        checks++;
        if (round_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_newmatch got rdy=%0b expected 1", round_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic r, nm, rv;
            logic [1:0] rr;
            r  = ($urandom_range(0, 49) == 0);
            nm = ($urandom_range(0, 11) == 0);
            rv = ($urandom_range(0, 3) != 0);
            rr = 2'($urandom_range(0, 3));
            cycle(r, nm, rv, rr);
        end
    endtask

    initial begin
        test_reset();
        test_p1_win();
        test_p2_win();
        test_invalid_sat();
        test_ties();
        test_done_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
